// File: rtl/instr_encoder_pkg.sv
// Shared constants and types for the PikaRISC instruction encoder/loader.
package instr_encoder_pkg;

  localparam logic [5:0] OP_LD   = 6'b100000;
  localparam logic [5:0] OP_STR  = 6'b100001;
  localparam logic [5:0] OP_CALL = 6'b100100;
  localparam logic [5:0] OP_RET  = 6'b100101;

  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RD_LSB  = 22;
  localparam int unsigned RS_LSB  = 18;
  localparam int unsigned RT_LSB  = 14;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Field stream in, memory write port out; master is the loader/memory side.
interface instr_encoder_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [5:0]        in_opcode;
  logic [3:0]        in_rd;
  logic [3:0]        in_rs;
  logic [3:0]        in_rt;
  logic [3:0]        in_cond;
  logic [17:0]       in_imm;
  logic [21:0]       in_mem;
  logic              mem_wr_en;
  logic              mem_wr_ready;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [31:0]       mem_wr_data;

  modport master (
    output in_valid, in_last, in_opcode, in_rd, in_rs, in_rt, in_cond, in_imm, in_mem,
    output mem_wr_ready,
    input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  in_valid, in_last, in_opcode, in_rd, in_rs, in_rt, in_cond, in_imm, in_mem,
    input  mem_wr_ready,
    output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/instr_encoder_fifo.sv
// Synchronous FIFO for packed words; push on full is honoured only with a same-cycle pop.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction field beats into 32-bit words and streams them into
// instruction memory from base_addr upward, with error and capacity tracking.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ADDR_W:0]   word_count
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] CAPACITY = (ADDR_W+1)'(1) << ADDR_W;

  state_t             state;
  state_t             state_nx;
  logic [ADDR_W-1:0]  base;
  logic [31:0]        enc_word;
  logic               enc_legal;
  logic [31:0]        head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ADDR_W:0]    reserved;
  logic               cap_full;
  logic               accept;
  logic               push;
  logic               pop;
  logic               overflow;

  // Words already written plus words queued; the next beat's address is base + reserved.
  assign reserved = word_count + (ADDR_W+1)'(fifo_count);
  assign cap_full = reserved == CAPACITY;

  assign bus.in_ready    = (state == S_LOAD) & ~fifo_full & ~cap_full;
  assign accept          = bus.in_valid & bus.in_ready;
  assign push            = accept & enc_legal;
  assign pop             = bus.mem_wr_en & bus.mem_wr_ready;
  assign overflow        = (state == S_LOAD) & cap_full & bus.in_valid & ~bus.in_last;
  assign bus.mem_wr_en   = ~fifo_empty;
  assign bus.mem_wr_addr = base + word_count[ADDR_W-1:0];
  assign bus.mem_wr_data = fifo_empty ? '0 : head;
  assign busy            = state != S_IDLE;
  assign done            = state == S_DONE;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    enc_word[OPC_LSB +: 6] = bus.in_opcode;
    casez (bus.in_opcode)
      6'b0????0: begin
        enc_word[RD_LSB +: 4] = bus.in_rd;
        enc_word[RS_LSB +: 4] = bus.in_rs;
        enc_word[RT_LSB +: 4] = bus.in_rt;
      end
      6'b0????1: begin
        enc_word[RD_LSB +: 4] = bus.in_rd;
        enc_word[RS_LSB +: 4] = bus.in_rs;
        enc_word[17:0]        = bus.in_imm;
      end
      6'b10001?: begin
        enc_word[RD_LSB +: 4] = bus.in_cond;
        enc_word[21:0]        = bus.in_mem;
      end
      OP_LD, OP_STR: begin
        enc_word[RD_LSB +: 4] = bus.in_rd;
        enc_word[21:0]        = bus.in_mem;
      end
      OP_CALL: enc_word[21:0] = bus.in_mem;
      OP_RET:  ;
      default: enc_legal = 1'b0;
    endcase
  end

  instr_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (enc_word),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  if ((accept & bus.in_last) | overflow) state_nx = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base       <= '0;
      word_count <= '0;
      err        <= '0;
      err_addr   <= '0;
    end else if (state == S_IDLE && start) begin
      base       <= base_addr;
      word_count <= '0;
      err        <= '0;
      err_addr   <= '0;
    end else begin
      if (pop) word_count <= word_count + 1'b1;
      if (accept && !enc_legal && !err[0]) begin
        err[0]   <= 1'b1;
        err_addr <= base + reserved[ADDR_W-1:0];
      end
      if (overflow) err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: scoreboard of expected memory writes plus a
// small-address-space instance for the capacity limit.
module tb_instr_encoder;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic       busy, done;
  logic [1:0] err;
  logic [7:0] err_addr;
  logic [8:0] word_count;

  logic       sstart;
  logic [1:0] sbase;
  logic       sbusy, sdone;
  logic [1:0] serr;
  logic [1:0] serr_addr;
  logic [2:0] swc;

  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t        sb[$];
  logic [7:0]  next_addr;
  int unsigned wr_cnt;
  logic [1:0]  s_next;
  int unsigned s_wr_cnt;

  instr_encoder_if #(.ADDR_W(8)) bus ();
  instr_encoder_if #(.ADDR_W(2)) sbus ();

  instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .bus(bus),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr), .word_count(word_count)
  );

  instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(2)) dut_small (
    .clk(clk), .rst(rst), .start(sstart), .base_addr(sbase), .bus(sbus),
    .busy(sbusy), .done(sdone), .err(serr), .err_addr(serr_addr), .word_count(swc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every cycle a write is offered it must match the oldest expectation; retire on handshake.
  always @(negedge clk) begin
    if (!rst && bus.mem_wr_en) begin
      if (sb.size() == 0) begin
        check("spurious_wr", 64'(bus.mem_wr_en), 64'(0));
      end else begin
        check("wr_addr", 64'(bus.mem_wr_addr), 64'(sb[0].addr));
        check("wr_data", 64'(bus.mem_wr_data), 64'(sb[0].data));
        if (bus.mem_wr_ready) begin
          void'(sb.pop_front());
          wr_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && sbus.mem_wr_en && sbus.mem_wr_ready) begin
      check("cap_wr_addr", 64'(sbus.mem_wr_addr), 64'(s_next));
      check("cap_wr_data", 64'(sbus.mem_wr_data), 64'(s_wr_cnt) << 22);
      s_next++;
      s_wr_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic start_session(input logic [7:0] b);
    base_addr = b;
    start     = 1'b1;
    next_addr = b;
    wr_cnt    = 0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_busy", 64'(busy), 64'(1));
    check("start_wc_clear", 64'(word_count), 64'(0));
    check("start_err_clear", 64'(err), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [3:0] rt, input logic [3:0] cond, input logic [17:0] imm,
                      input logic [21:0] mem, input logic last, input logic legal,
                      input logic [31:0] word);
    int unsigned n = 0;
    logic acc = 1'b0;
    bus.in_valid = 1'b1; bus.in_last = last; bus.in_opcode = op;
    bus.in_rd = rd; bus.in_rs = rs; bus.in_rt = rt; bus.in_cond = cond;
    bus.in_imm = imm; bus.in_mem = mem;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    check("beat_accept", 64'(acc), 64'(1));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (acc && legal) begin
      sb.push_back('{addr: next_addr, data: word});
      next_addr++;
    end
  endtask

  task automatic wait_done(input string tag);
    int unsigned n = 0;
    logic seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    check({tag, "_done"}, 64'(seen), 64'(1));
    @(negedge clk);
    check({tag, "_done_width"}, 64'(done), 64'(0));
    check({tag, "_idle"}, 64'(busy), 64'(0));
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned n;
    int unsigned dn;
    logic acc;

    rst = 1'b1; start = 1'b0; base_addr = '0; sstart = 1'b0; sbase = '0;
    bus.in_valid = 0; bus.in_last = 0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs = '0;
    bus.in_rt = '0; bus.in_cond = '0; bus.in_imm = '0; bus.in_mem = '0; bus.mem_wr_ready = 1'b1;
    sbus.in_valid = 0; sbus.in_last = 0; sbus.in_opcode = '0; sbus.in_rd = '0; sbus.in_rs = '0;
    sbus.in_rt = '0; sbus.in_cond = '0; sbus.in_imm = '0; sbus.in_mem = '0; sbus.mem_wr_ready = 1'b1;
    wr_cnt = 0; s_wr_cnt = 0; s_next = '0; next_addr = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_wr_en", 64'(bus.mem_wr_en), 64'(0));
    check("rst_done_busy", 64'({done, busy}), 64'(0));
    check("rst_err", 64'({err, err_addr}), 64'(0));
    check("rst_wc", 64'(word_count), 64'(0));
    check("rst_wr_bus", 64'({bus.mem_wr_addr, bus.mem_wr_data}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU register form; imm/cond/mem inputs carry junk that must be ignored
    start_session(8'h10);
    send(6'b000000, 4'd1, 4'd2, 4'd3, 4'hA, 18'h2AAAA, 22'h3FFFFF, 1'b1, 1'b1, 32'h0048C000);
    wait_done("alu_reg");
    check("alu_reg_wc", 64'(word_count), 64'(1));
    check("alu_reg_writes", 64'(wr_cnt), 64'(1));
    check("alu_reg_err", 64'(err), 64'(0));

    // ALU immediate (rt ignored) then jump
    start_session(8'h20);
    send(6'b000001, 4'd4, 4'd5, 4'd7, 4'hA, 18'h3FFFF, 22'h3FFFFF, 1'b0, 1'b1, 32'h0517FFFF);
    send(6'b100010, 4'd9, 4'd9, 4'd9, 4'hF, 18'h15555, 22'h123456, 1'b1, 1'b1, 32'h8BD23456);
    wait_done("imm_jmp");
    check("imm_jmp_wc", 64'(word_count), 64'(2));

    // Memory/call/return forms streamed back to back
    start_session(8'h30);
    send(OP_LD_C,   4'd5, 4'd3, 4'd3, 4'd3, 18'h3FFFF, 22'h02AAAA, 1'b0, 1'b1, 32'h8142AAAA);
    send(OP_STR_C,  4'hA, 4'd1, 4'd1, 4'd1, 18'h3FFFF, 22'h000001, 1'b0, 1'b1, 32'h86800001);
    send(OP_CALL_C, 4'hF, 4'hF, 4'hF, 4'hF, 18'h3FFFF, 22'h3FFFFF, 1'b0, 1'b1, 32'h903FFFFF);
    send(OP_RET_C,  4'hF, 4'hF, 4'hF, 4'hF, 18'h3FFFF, 22'h3FFFFF, 1'b1, 1'b1, 32'h94000000);
    wait_done("mem_forms");
    check("mem_forms_wc", 64'(word_count), 64'(4));

    // Backpressure across the top of the address space
    bus.mem_wr_ready = 1'b0;
    start_session(8'hFE);
    send(6'b000000, 4'd1, 4'd2, 4'd0, 4'd0, 18'h0, 22'h0, 1'b0, 1'b1, 32'h00480000);
    send(6'b000000, 4'd2, 4'd0, 4'd5, 4'd0, 18'h0, 22'h0, 1'b0, 1'b1, 32'h00814000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("full_in_ready", 64'(bus.in_ready), 64'(0));
      check("stall_wr_en", 64'(bus.mem_wr_en), 64'(1));
      @(posedge clk); #1;
    end
    bus.mem_wr_ready = 1'b1;
    send(6'b000000, 4'd3, 4'd4, 4'd5, 4'd0, 18'h0, 22'h0, 1'b1, 1'b1, 32'h00D14000);
    wait_done("wrap");
    check("wrap_wc", 64'(word_count), 64'(3));
    check("wrap_writes", 64'(wr_cnt), 64'(3));

    // Illegal beats dropped; first one's address captured
    start_session(8'h40);
    send(6'b000000, 4'd6, 4'd0, 4'd0, 4'd0, 18'h0, 22'h0, 1'b0, 1'b1, 32'h01800000);
    send(6'b110000, 4'd1, 4'd1, 4'd1, 4'd1, 18'h1, 22'h1, 1'b0, 1'b0, 32'h0);
    send(6'b111110, 4'd1, 4'd1, 4'd1, 4'd1, 18'h1, 22'h1, 1'b0, 1'b0, 32'h0);
    send(6'b000000, 4'd7, 4'd0, 4'd0, 4'd0, 18'h0, 22'h0, 1'b1, 1'b1, 32'h01C00000);
    wait_done("illegal");
    check("illegal_err", 64'(err), 64'(2'b01));
    check("illegal_err_addr", 64'(err_addr), 64'(8'h41));
    check("illegal_wc", 64'(word_count), 64'(2));
    check("illegal_writes", 64'(wr_cnt), 64'(2));

    // Illegal beat carrying last still ends the session
    start_session(8'h50);
    send(6'b111111, 4'd1, 4'd1, 4'd1, 4'd1, 18'h1, 22'h1, 1'b1, 1'b0, 32'h0);
    wait_done("illegal_last");
    check("illegal_last_err", 64'({err, err_addr}), 64'({2'b01, 8'h50}));
    check("illegal_last_wc", 64'(word_count), 64'(0));

    // Capacity on a 4-word memory: four beats fit, the fifth overflows
    sbase = 2'd3; s_next = 2'd3; s_wr_cnt = 0; sstart = 1'b1;
    @(posedge clk); #1;
    sstart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sbus.in_valid = 1'b1; sbus.in_rd = 4'(i);
      acc = 1'b0; n = 0;
      while (!acc && n < 50) begin
        @(negedge clk);
        acc = sbus.in_ready;
        @(posedge clk); #1;
        n++;
      end
      check("cap_accept", 64'(acc), 64'(1));
    end
    sbus.in_rd = 4'd4;
    acc = 1'b0; dn = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sbus.in_ready) acc = 1'b1;
      if (sdone) dn++;
      @(posedge clk); #1;
    end
    sbus.in_valid = 1'b0;
    check("cap_reject", 64'(acc), 64'(0));
    check("cap_done", 64'(dn), 64'(1));
    check("cap_writes", 64'(s_wr_cnt), 64'(4));
    check("cap_err", 64'(serr), 64'(2'b10));
    check("cap_wc", 64'(swc), 64'(4));
    check("cap_idle", 64'(sbusy), 64'(0));

    // Reset while two words sit in the FIFO
    bus.mem_wr_ready = 1'b0;
    start_session(8'h60);
    send(6'b000000, 4'd1, 4'd0, 4'd0, 4'd0, 18'h0, 22'h0, 1'b0, 1'b1, 32'h00400000);
    send(6'b000000, 4'd2, 4'd0, 4'd0, 4'd0, 18'h0, 22'h0, 1'b0, 1'b1, 32'h00800000);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_wr_en", 64'(bus.mem_wr_en), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_wr_ready = 1'b1;
    dn = 0; acc = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) dn++;
      if (bus.mem_wr_en) acc = 1'b1;
      @(posedge clk); #1;
    end
    check("midrst_no_done", 64'(dn), 64'(0));
    check("midrst_no_write", 64'(acc), 64'(0));
    check("midrst_outputs", 64'({busy, done, bus.in_ready, err, err_addr, word_count}), 64'(0));
    check("midrst_wr_bus", 64'({bus.mem_wr_addr, bus.mem_wr_data}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  localparam logic [5:0] OP_LD_C   = 6'b100000;
  localparam logic [5:0] OP_STR_C  = 6'b100001;
  localparam logic [5:0] OP_CALL_C = 6'b100100;
  localparam logic [5:0] OP_RET_C  = 6'b100101;

endmodule
